leg_instruction_fetch: RTL and testbench

- Front-end stage of the LEG core. Owns the program counter and reads each 4-byte instruction (OP_Code, ARG1, ARG2, DEST) from a byte-wide program memory, one byte per handshake.
- Presents the assembled instruction to the opcode/address-bus decode stage with a valid/ready handshake.
- OP_Code goes straight to the decoder, which derives the immediate and shift controls.
- Accepts redirects (jumps/branches) from the condition unit.

---
 rtl/leg_fetch_pkg.sv | 18 +
 rtl/leg_instruction_fetch.sv | 145 ++++++++++++++
 tb/tb_leg_instruction_fetch.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/leg_fetch_pkg.sv
// LEG instruction fetch: shared types and constants.
// State encoding and byte-lane names for the 4-byte instruction word.
package leg_fetch_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  localparam logic [1:0] IDX_OP   = 2'd0;
  localparam logic [1:0] IDX_ARG1 = 2'd1;
  localparam logic [1:0] IDX_ARG2 = 2'd2;
  localparam logic [1:0] IDX_DEST = 2'd3;

endpackage

// File: rtl/leg_instruction_fetch.sv
// LEG front end: owns the PC, fetches 4 bytes per instruction
// from byte-wide memory and hands the word to decode.
module leg_instruction_fetch
  import leg_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            op_code,
  output logic [7:0]            arg1,
  output logic [7:0]            arg2,
  output logic [7:0]            dest,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  fetch_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  // bytes 0..2 of the word in flight, hidden until byte 3 lands
  logic [7:0] p_op_q, p_op_d;
  logic [7:0] p_a1_q, p_a1_d;
  logic [7:0] p_a2_q, p_a2_d;
  // presented instruction fields
  logic [7:0] op_q, op_d;
  logic [7:0] a1_q, a1_d;
  logic [7:0] a2_q, a2_d;
  logic [7:0] dst_q, dst_d;

  // Next-state, capture and PC update; redirect overrides all.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    ipc_d   = ipc_q;
    p_op_d  = p_op_q;
    p_a1_d  = p_a1_q;
    p_a2_d  = p_a2_q;
    op_d    = op_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    dst_d   = dst_q;
    unique case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        if (mem_ack) begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            IDX_OP:   p_op_d = mem_rdata;
            IDX_ARG1: p_a1_d = mem_rdata;
            IDX_ARG2: p_a2_d = mem_rdata;
            IDX_DEST: begin
              op_d    = p_op_q;
              a1_d    = p_a1_q;
              a2_d    = p_a2_q;
              dst_d   = mem_rdata;
              ipc_d   = base_q;
              idx_d   = 2'd0;
              state_d = HOLD;
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        if (instr_ready) begin
          base_d  = base_q + ADDR_WIDTH'(INSTR_BYTES);
          state_d = FETCH;
        end
      end
      default: state_d = START;
    endcase
    if (pc_load) begin
      base_d  = pc_target;
      idx_d   = 2'd0;
      state_d = FETCH;
      ipc_d   = ipc_q;
      p_op_d  = p_op_q;
      p_a1_d  = p_a1_q;
      p_a2_d  = p_a2_q;
      op_d    = op_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      dst_d   = dst_q;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
      idx_q   <= 2'd0;
      base_q  <= '0;
      ipc_q   <= '0;
      p_op_q  <= 8'd0;
      p_a1_q  <= 8'd0;
      p_a2_q  <= 8'd0;
      op_q    <= 8'd0;
      a1_q    <= 8'd0;
      a2_q    <= 8'd0;
      dst_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      ipc_q   <= ipc_d;
      p_op_q  <= p_op_d;
      p_a1_q  <= p_a1_d;
      p_a2_q  <= p_a2_d;
      op_q    <= op_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      dst_q   <= dst_d;
    end
  end

  // Memory request is live only while fetching.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    if (state_q == FETCH) begin
      mem_req  = 1'b1;
      mem_addr = base_q + ADDR_WIDTH'(idx_q);
    end
  end

  assign instr_valid = (state_q == HOLD);
  assign op_code     = op_q;
  assign arg1        = a1_q;
  assign arg2        = a2_q;
  assign dest        = dst_q;
  assign instr_pc    = ipc_q;
  assign pc          = base_q;

endmodule

// File: tb/tb_leg_instruction_fetch.sv
// Directed bench for leg_instruction_fetch with a
// byte memory model and hand-computed expectations.
module tb_leg_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       pc_load;
  logic [7:0] pc_target;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] op_code, arg1, arg2, dest;
  logic [7:0] instr_pc, pc;

  logic [7:0] mem [256];
  logic       ack_en;
  int         errors = 0;
  int         checks = 0;
  int         xfers  = 0;

  always #5 clk = ~clk;

  leg_instruction_fetch #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_load(pc_load), .pc_target(pc_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_code(op_code), .arg1(arg1), .arg2(arg2), .dest(dest),
    .instr_pc(instr_pc), .pc(pc)
  );

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req & ack_en;

  always @(posedge clk)
    if (!rst && instr_valid && instr_ready) xfers++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fields(string tag, logic [7:0] o, logic [7:0] a,
                            logic [7:0] b, logic [7:0] d, logic [7:0] ip);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".op"}, 32'(op_code), 32'(o));
    chk({tag, ".arg1"}, 32'(arg1), 32'(a));
    chk({tag, ".arg2"}, 32'(arg2), 32'(b));
    chk({tag, ".dest"}, 32'(dest), 32'(d));
    chk({tag, ".ipc"}, 32'(instr_pc), 32'(ip));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h00] = 8'h81; mem[8'h01] = 8'h05;
    mem[8'h02] = 8'h03; mem[8'h03] = 8'h02;
    mem[8'h04] = 8'h11; mem[8'h05] = 8'h22;
    mem[8'h06] = 8'h33; mem[8'h07] = 8'h44;
    mem[8'h40] = 8'hA1; mem[8'h41] = 8'hA2;
    mem[8'h42] = 8'hA3; mem[8'h43] = 8'hA4;
    mem[8'hFE] = 8'hC1; mem[8'hFF] = 8'hC2;
    rst = 1'b1; ack_en = 1'b1; pc_load = 1'b0;
    pc_target = 8'h00; instr_ready = 1'b0;
    step(); step();
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.addr", 32'(mem_addr), 32'd0);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.fields", {op_code, arg1, arg2, dest}, 32'd0);
    rst = 1'b0;
    // START cycle
    chk("start.req", 32'(mem_req), 32'd0);
    step(); chk("f0.addr", {mem_req, mem_addr}, {23'd0, 1'b1, 8'h00});
    step(); chk("f1.addr", {mem_req, mem_addr}, {23'd0, 1'b1, 8'h01});
    step(); chk("f2.addr", {mem_req, mem_addr}, {23'd0, 1'b1, 8'h02});
    step(); chk("f3.addr", {mem_req, mem_addr}, {23'd0, 1'b1, 8'h03});
    chk("f3.valid", 32'(instr_valid), 32'd0);
    step(); chk_fields("i0", 8'h81, 8'h05, 8'h03, 8'h02, 8'h00);
    chk("i0.req", 32'(mem_req), 32'd0);
    // decode stalls three cycles
    step(); step(); step();
    chk_fields("stall", 8'h81, 8'h05, 8'h03, 8'h02, 8'h00);
    chk("stall.req", 32'(mem_req), 32'd0);
    chk("stall.xfers", xfers, 0);
    instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    chk("i1.valid", 32'(instr_valid), 32'd0);
    chk("i1.addr", 32'(mem_addr), 32'h04);
    chk("i1.pc", 32'(pc), 32'h04);
    chk("i1.xfers", xfers, 1);
    // two wait cycles on byte 2
    step(); chk("w.a5", 32'(mem_addr), 32'h05);
    step(); chk("w.a6", 32'(mem_addr), 32'h06);
    ack_en = 1'b0;
    step(); chk("w.hold1", {mem_req, mem_addr}, {23'd0, 1'b1, 8'h06});
    step(); chk("w.hold2", {mem_req, mem_addr}, {23'd0, 1'b1, 8'h06});
    ack_en = 1'b1;
    step(); chk("w.a7", 32'(mem_addr), 32'h07);
    chk("w.novalid", 32'(instr_valid), 32'd0);
    step(); chk_fields("i1", 8'h11, 8'h22, 8'h33, 8'h44, 8'h04);
    // redirect alone in HOLD: no transfer
    pc_load = 1'b1; pc_target = 8'h80;
    step(); pc_load = 1'b0;
    chk("ld.valid", 32'(instr_valid), 32'd0);
    chk("ld.addr", 32'(mem_addr), 32'h80);
    chk("ld.xfers", xfers, 1);
    // redirect mid-word at idx 2
    step(); chk("m.a81", 32'(mem_addr), 32'h81);
    step(); chk("m.a82", 32'(mem_addr), 32'h82);
    pc_load = 1'b1; pc_target = 8'h40;
    step(); pc_load = 1'b0;
    chk("m.a40", 32'(mem_addr), 32'h40);
    chk("m.pc", 32'(pc), 32'h40);
    step(); step(); step();
    chk("m.novalid", 32'(instr_valid), 32'd0);
    step(); chk_fields("i2", 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h40);
    // redirect plus ready in HOLD: one transfer, resume at target
    pc_load = 1'b1; pc_target = 8'hFE; instr_ready = 1'b1;
    step(); pc_load = 1'b0; instr_ready = 1'b0;
    chk("lr.xfers", xfers, 2);
    chk("lr.valid", 32'(instr_valid), 32'd0);
    chk("wrap.aFE", 32'(mem_addr), 32'hFE);
    step(); chk("wrap.aFF", 32'(mem_addr), 32'hFF);
    step(); chk("wrap.a00", 32'(mem_addr), 32'h00);
    step(); chk("wrap.a01", 32'(mem_addr), 32'h01);
    step(); chk_fields("i3", 8'hC1, 8'hC2, 8'h81, 8'h05, 8'hFE);
    instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    chk("wrap.a02", 32'(mem_addr), 32'h02);
    chk("wrap.pc", 32'(pc), 32'h02);
    chk("wrap.xfers", xfers, 3);
    step(); chk("pre.a03", 32'(mem_addr), 32'h03);
    // asynchronous reset mid-fetch
    #2 rst = 1'b1;
    #1;
    chk("arst.req", {mem_req, mem_addr}, 32'd0);
    chk("arst.pc", {instr_pc, pc}, 32'd0);
    chk("arst.fields", {op_code, arg1, arg2, dest}, 32'd0);
    chk("arst.valid", 32'(instr_valid), 32'd0);
    step(); rst = 1'b0;
    chk("rs.start", 32'(mem_req), 32'd0);
    step(); chk("rs.f0", {mem_req, mem_addr}, {23'd0, 1'b1, 8'h00});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
